// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
// Imported by the fetch stage and its PC register.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int XLEN = 32;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int IMEM_WORDS_DEFAULT = 64;

    typedef enum logic [1:0] {
        SEL_ADV,
        SEL_HOLD,
        SEL_BR,
        SEL_JMP
    } pc_sel_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc4;
        logic               valid;
    } if_id_t;

    function automatic logic [XLEN-1:0] word_align(
        input logic [XLEN-1:0] addr
    );
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC selection and fetch checks.
// Redirect beats stall; branch beats jump.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    output pc_sel_e         sel,
    output logic            misaligned,
    output logic            out_of_range
);

    // 34-bit compare so large IMEM_WORDS cannot overflow the limit
    localparam logic [XLEN+1:0] LIMIT =
        (XLEN+2)'(IMEM_WORDS) << 2;

    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_next;

    always_comb begin
        sel = SEL_ADV;
        priority case (1'b1)
            branch_taken: sel = SEL_BR;
            jump:         sel = SEL_JMP;
            stall:        sel = SEL_HOLD;
            default:      sel = SEL_ADV;
        endcase
    end

    always_comb begin
        target = jump_target;
        if (sel == SEL_BR) begin
            target = branch_target;
        end
    end

    assign pc4 = pc + 32'd4;

    assign misaligned =
        ((sel == SEL_BR) || (sel == SEL_JMP)) &&
        (target[1:0] != 2'b00);

    assign out_of_range = {2'b00, pc} >= LIMIT;

    always_comb begin
        pc_next = pc4;
        unique case (sel)
            SEL_BR,
            SEL_JMP:  pc_next = word_align(target);
            SEL_HOLD: pc_next = pc;
            SEL_ADV:  pc_next = pc4;
            default:  pc_next = pc4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, imem address, IF/ID register.
// Bubbles on redirect and on out-of-range fetches.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    output logic [XLEN-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [XLEN-1:0]    branch_target,
    input  logic               jump,
    input  logic [XLEN-1:0]    jump_target,
    output logic [XLEN-1:0]    pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [XLEN-1:0]    if_id_pc4,
    output logic               if_id_valid,
    output logic               fetch_fault,
    output logic [31:0]        fetch_count
);

    pc_sel_e         sel;
    logic [XLEN-1:0] pc4;
    logic            misaligned;
    logic            out_of_range;
    if_id_t          if_id;

    pc_reg #(
        .RESET_PC   (RESET_PC),
        .IMEM_WORDS (IMEM_WORDS)
    ) u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc            (pc),
        .pc4           (pc4),
        .sel           (sel),
        .misaligned    (misaligned),
        .out_of_range  (out_of_range)
    );

    assign imem_addr = pc;

    // Bubbles keep the old pc4; only instr and valid are cleared
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id       <= '0;
            fetch_fault <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            unique case (sel)
                SEL_BR,
                SEL_JMP: begin
                    if_id.instr <= NOP;
                    if_id.valid <= 1'b0;
                    if (misaligned) begin
                        fetch_fault <= 1'b1;
                    end
                end
                SEL_HOLD: begin
                end
                SEL_ADV: begin
                    if (out_of_range) begin
                        if_id.instr <= NOP;
                        if_id.valid <= 1'b0;
                        fetch_fault <= 1'b1;
                    end else begin
                        if_id.instr <= imem_data;
                        if_id.pc4   <= pc4;
                        if_id.valid <= 1'b1;
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign if_id_instr = if_id.instr;
    assign if_id_pc4   = if_id.pc4;
    assign if_id_valid = if_id.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage against a small word memory.
// Inputs change and outputs are checked 1ns after posedge.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [64];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC   (32'h0),
        .IMEM_WORDS (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .fetch_fault   (fetch_fault),
        .fetch_count   (fetch_count)
    );

    assign imem_data = (imem_addr < 32'd256)
        ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(
        input string       tag,
        input logic [31:0] e_pc,
        input logic [31:0] e_instr,
        input logic [31:0] e_pc4,
        input logic        e_valid,
        input logic        e_fault,
        input logic [31:0] e_count
    );
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".addr"}, imem_addr, e_pc);
        chk({tag, ".instr"}, if_id_instr, e_instr);
        chk({tag, ".pc4"}, if_id_pc4, e_pc4);
        chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, e_valid});
        chk({tag, ".fault"}, {31'b0, fetch_fault}, {31'b0, e_fault});
        chk({tag, ".count"}, fetch_count, e_count);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h1000_0000 + i;
        end
        mem[0] = 32'h2008_0020;
        mem[1] = 32'h2009_0037;

        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        jump = 1'b0;
        branch_target = 32'h0;
        jump_target = 32'h0;
        step();
        step();
        chk_all("rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

        reset = 1'b0;
        step();
        chk_all("f0", 32'h4, 32'h2008_0020, 32'h4, 1'b1, 1'b0, 32'd1);
        step();
        chk_all("f1", 32'h8, 32'h2009_0037, 32'h8, 1'b1, 1'b0, 32'd2);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("stl", 32'h8, 32'h2009_0037, 32'h8,
                    1'b1, 1'b0, 32'd2);
        end
        stall = 1'b0;
        step();
        chk_all("rel", 32'hC, 32'h1000_0002, 32'hC, 1'b1, 1'b0, 32'd3);
        step();
        chk_all("f3", 32'h10, 32'h1000_0003, 32'h10, 1'b1, 1'b0, 32'd4);

        branch_taken = 1'b1;
        branch_target = 32'h40;
        step();
        chk_all("br", 32'h40, 32'h0, 32'h10, 1'b0, 1'b0, 32'd4);
        branch_taken = 1'b0;
        step();
        chk_all("brt", 32'h44, 32'h1000_0010, 32'h44, 1'b1, 1'b0, 32'd5);

        branch_taken = 1'b1;
        branch_target = 32'h20;
        jump = 1'b1;
        jump_target = 32'h80;
        stall = 1'b1;
        step();
        chk_all("all3", 32'h20, 32'h0, 32'h44, 1'b0, 1'b0, 32'd5);
        branch_taken = 1'b0;
        stall = 1'b0;
        jump_target = 32'h22;
        step();
        chk_all("mis", 32'h20, 32'h0, 32'h44, 1'b0, 1'b1, 32'd5);
        jump = 1'b0;
        step();
        chk_all("mis2", 32'h24, 32'h1000_0008, 32'h24, 1'b1, 1'b1, 32'd6);
        step();
        chk_all("mis3", 32'h28, 32'h1000_0009, 32'h28, 1'b1, 1'b1, 32'd7);

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all("rst2", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        jump = 1'b1;
        jump_target = 32'hFC;
        step();
        chk_all("j", 32'hFC, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        jump = 1'b0;
        step();
        chk_all("last", 32'h100, 32'h1000_003F, 32'h100, 1'b1, 1'b0, 32'd1);
        step();
        chk_all("oor", 32'h104, 32'h0, 32'h100, 1'b0, 1'b1, 32'd1);
        stall = 1'b1;
        step();
        chk_all("oor_stl", 32'h104, 32'h0, 32'h100, 1'b0, 1'b1, 32'd1);
        reset = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h80;
        step();
        chk_all("rst3", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

        reset = 1'b0;
        branch_taken = 1'b0;
        stall = 1'b0;
        jump = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        step();
        chk_all("hi", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        jump = 1'b0;
        step();
        chk_all("wrap", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd0);
        step();
        chk_all("wrap2", 32'h4, 32'h2008_0020, 32'h4, 1'b1, 1'b1, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
